// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_pkg
// Brief    : Shared mode encoding, flag bit positions and helpers for pipe_adder.
// Revision : 1.0
// ============================================================================
package pipe_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_ADC = 2'b01,
        MODE_SUB = 2'b10,
        MODE_SBB = 2'b11
    } mode_e;

    localparam int FLAG_CF   = 0;
    localparam int FLAG_PF   = 1;
    localparam int FLAG_AF   = 2;
    localparam int FLAG_ZF   = 3;
    localparam int FLAG_SF   = 4;
    localparam int FLAG_OF   = 5;
    localparam int NUM_FLAGS = 6;

    function automatic logic even_parity8(input logic [7:0] v);
        return ~(^v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_adder_slice.sv
`default_nettype none
// ============================================================================
// Module   : adder_slice
// Brief    : Combinational SW-bit add with carry-into-MSB and bit AF_BIT carry.
// Revision : 1.0
// ============================================================================
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int SW     = 8,
    parameter int AF_BIT = 3
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o,
    output logic          cmsb_o,
    output logic          c3_o
);

    logic [SW:0] w_full;

    assign w_full = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};
    assign sum_o  = w_full[SW-1:0];
    assign cout_o = w_full[SW];

    // Carry into a bit is recovered as a ^ b ^ sum at that bit.
    assign cmsb_o = a_i[SW-1] ^ b_i[SW-1] ^ sum_o[SW-1];

    if (AF_BIT + 1 < SW) begin : g_c3_inner
        assign c3_o = a_i[AF_BIT+1] ^ b_i[AF_BIT+1] ^ sum_o[AF_BIT+1];
    end else begin : g_c3_top
        assign c3_o = w_full[SW];
    end

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Brief    : STAGES-deep carry-chained add/sub with x86 flags and valid/ready.
// Revision : 1.0
// ============================================================================
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [5:0]       out_flags
);

    localparam int SW       = WIDTH / STAGES;
    localparam int AF_STAGE = 3 / SW;
    localparam int AF_LOCAL = 3 % SW;

    logic             w_en;
    logic             w_sub;
    logic             w_c0;
    logic [WIDTH-1:0] w_bp;

    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;
    assign w_sub    = in_mode[1];
    assign w_bp     = w_sub ? ~in_b : in_b;

    always_comb begin
        w_c0 = 1'b0;
        case (mode_e'(in_mode))
            MODE_ADD: w_c0 = 1'b0;
            MODE_ADC: w_c0 = in_cf;
            MODE_SUB: w_c0 = 1'b1;
            MODE_SBB: w_c0 = ~in_cf;
            default:  w_c0 = 1'b0;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet added, including this stage's slice.
        localparam int REM = WIDTH - k * SW;

        logic [REM-1:0]        w_a;
        logic [REM-1:0]        w_b;
        logic                  w_cin;
        logic                  w_op_sub;
        logic                  w_v;
        logic                  w_af_in;
        logic [SW-1:0]         w_slice_sum;
        logic                  w_cout;
        logic                  w_cmsb;
        logic                  w_c3;
        logic                  w_af;
        logic [(k+1)*SW-1:0]   w_sum_cat;

        if (k == 0) begin : g_src_in
            assign w_a       = in_a;
            assign w_b       = w_bp;
            assign w_cin     = w_c0;
            assign w_op_sub  = w_sub;
            assign w_v       = in_valid;
            assign w_af_in   = 1'b0;
            assign w_sum_cat = w_slice_sum;
        end else begin : g_src_prev
            assign w_a       = g_stage[k-1].g_skew.a_q;
            assign w_b       = g_stage[k-1].g_skew.b_q;
            assign w_cin     = g_stage[k-1].g_skew.c_q;
            assign w_op_sub  = g_stage[k-1].g_skew.sub_q;
            assign w_v       = g_stage[k-1].g_skew.v_q;
            assign w_af_in   = g_stage[k-1].g_skew.af_q;
            assign w_sum_cat = {w_slice_sum, g_stage[k-1].g_skew.sum_q};
        end

        adder_slice #(
            .SW     (SW),
            .AF_BIT ((k == AF_STAGE) ? AF_LOCAL : 0)
        ) u_slice (
            .a_i    (w_a[SW-1:0]),
            .b_i    (w_b[SW-1:0]),
            .cin_i  (w_cin),
            .sum_o  (w_slice_sum),
            .cout_o (w_cout),
            .cmsb_o (w_cmsb),
            .c3_o   (w_c3)
        );

        assign w_af = (k == AF_STAGE) ? (w_c3 ^ w_op_sub) : w_af_in;

        if (k < STAGES - 1) begin : g_skew
            logic [REM-SW-1:0]   a_q;
            logic [REM-SW-1:0]   b_q;
            logic [(k+1)*SW-1:0] sum_q;
            logic                c_q;
            logic                af_q;
            logic                sub_q;
            logic                v_q;
            logic                w_unused_cmsb;

            assign w_unused_cmsb = w_cmsb;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    af_q  <= 1'b0;
                    sub_q <= 1'b0;
                    v_q   <= 1'b0;
                end else if (w_en) begin
                    a_q   <= w_a[REM-1:SW];
                    b_q   <= w_b[REM-1:SW];
                    sum_q <= w_sum_cat;
                    c_q   <= w_cout;
                    af_q  <= w_af;
                    sub_q <= w_op_sub;
                    v_q   <= w_v;
                end
            end
        end else begin : g_final
            logic [WIDTH-1:0] sum_q;
            logic [5:0]       flags_d;
            logic [5:0]       flags_q;
            logic             v_q;

            always_comb begin
                flags_d          = '0;
                flags_d[FLAG_CF] = w_cout ^ w_op_sub;
                flags_d[FLAG_PF] = even_parity8(w_sum_cat[7:0]);
                flags_d[FLAG_AF] = w_af;
                flags_d[FLAG_ZF] = (w_sum_cat == '0);
                flags_d[FLAG_SF] = w_sum_cat[WIDTH-1];
                flags_d[FLAG_OF] = w_cmsb ^ w_cout;
            end

            // Sum and flags share one register so they can never skew apart.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sum_q   <= '0;
                    flags_q <= '0;
                    v_q     <= 1'b0;
                end else if (w_en) begin
                    sum_q   <= w_sum_cat;
                    flags_q <= flags_d;
                    v_q     <= w_v;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].g_final.v_q;
    assign out_sum   = g_stage[STAGES-1].g_final.sum_q;
    assign out_flags = g_stage[STAGES-1].g_final.flags_q;

endmodule
`default_nettype wire
